imem_responder: RTL and testbench

Clocked instruction-memory responder for the two-phase trigger/ready handshake the fetch stage uses as initiator.
- Synchronises the asynchronous request toggle and captures the fetch address.
- Waits a programmable access latency, then returns the 32-bit instruction word and toggles readyOut.
- Has a preload port, so benches and boot logic can fill the array.
- Replaces the behavioural rom behind fetch.

---
 rtl/imem_responder.sv | 141 ++++++++++++++
 tb/tb_imem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for the fetch stage's two-phase
// trigger/ready toggle handshake. Each request toggle is synchronised and the
// fetch address is captured. After LATENCY wait cycles the instruction word is
// returned, and readyOut is set equal to the serviced trigger level.
//
// Ports:
//   clk, resetN            rising-edge clock, asynchronous active-low reset
//   triggerIn              request toggle (asynchronous to clk)
//   addrIn [31:0]          byte address, held stable until readyOut == triggerIn
//   dataOut [31:0]         instruction word, valid from the readyOut toggle edge
//   readyOut               acknowledge toggle
//   errOut                 last access was misaligned or out of range
//   busy                   access in flight
//   loadEn/loadAddr/loadData  preload write port, usable in any state
module imem_responder #(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] NOP_WORD    = 32'hE1A00000
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  triggerIn,
    input  logic [31:0]           addrIn,
    output logic [31:0]           dataOut,
    output logic                  readyOut,
    output logic                  errOut,
    output logic                  busy,
    input  logic                  loadEn,
    input  logic [DEPTH_LOG2-1:0] loadAddr,
    input  logic [31:0]           loadData
);

    localparam int unsigned Depth  = 1 << DEPTH_LOG2;
    localparam int unsigned CntW   = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int unsigned IdxMsb = DEPTH_LOG2 + 1;
    localparam int unsigned HiLsb  = DEPTH_LOG2 + 2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    logic [31:0]            mem [Depth];
    logic [SYNC_STAGES-1:0] syncFf;
    logic                   trigSync;

    state_t                 state, stateNext;
    logic                   trigSeen, trigSeenNext;
    logic [31:0]            addrReg, addrNext;
    logic [CntW-1:0]        cnt, cntNext;
    logic [31:0]            dataNext;
    logic                   readyNext, errNext, busyNext;

    logic                   accErr;
    logic [31:0]            rdWord;

    // Preload port; the array has no reset.
    always_ff @(posedge clk) begin
        if (loadEn) begin
            mem[loadAddr] <= loadData;
        end
    end

    // triggerIn synchroniser
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            syncFf <= '0;
        end else begin
            syncFf <= {syncFf[SYNC_STAGES-2:0], triggerIn};
        end
    end

    assign trigSync = syncFf[SYNC_STAGES-1];

    // Address decode and array read, both taken at the response edge
    assign accErr = (addrReg[1:0] != 2'b00) || (addrReg[31:HiLsb] != '0);
    assign rdWord = mem[addrReg[IdxMsb:2]];

    // State and registered outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            trigSeen <= 1'b0;
            addrReg  <= '0;
            cnt      <= '0;
            dataOut  <= '0;
            readyOut <= 1'b0;
            errOut   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= stateNext;
            trigSeen <= trigSeenNext;
            addrReg  <= addrNext;
            cnt      <= cntNext;
            dataOut  <= dataNext;
            readyOut <= readyNext;
            errOut   <= errNext;
            busy     <= busyNext;
        end
    end

    // Next-state and next-output logic.
    // Trigger toggles that arrive while in WAIT are not queued; only the level
    // that trigSync holds on return to IDLE is compared against trigSeen.
    always_comb begin
        stateNext    = state;
        trigSeenNext = trigSeen;
        addrNext     = addrReg;
        cntNext      = cnt;
        dataNext     = dataOut;
        readyNext    = readyOut;
        errNext      = errOut;
        busyNext     = busy;

        case (state)
            IDLE: begin
                if (trigSync != trigSeen) begin
                    trigSeenNext = trigSync;
                    addrNext     = addrIn;
                    cntNext      = CntW'(LATENCY);
                    busyNext     = 1'b1;
                    stateNext    = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cntNext = cnt - CntW'(1);
                end else begin
                    dataNext  = accErr ? NOP_WORD : rdWord;
                    errNext   = accErr;
                    readyNext = trigSeen;
                    busyNext  = 1'b0;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder. u0 uses the default parameters (LATENCY=2).
// u1 is built with LATENCY=0. Both share the clock, the reset and the preload port.
module tb_imem_responder;

    localparam logic [31:0] Nop = 32'hE1A00000;

    logic        clk = 1'b0;
    logic        resetN;
    logic        loadEn;
    logic [7:0]  loadAddr;
    logic [31:0] loadData;

    logic        trig0, trig1;
    logic [31:0] addr0, addr1;
    logic [31:0] data0, data1;
    logic        ready0, ready1, err0, err1, busy0, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_responder u0 (
        .clk(clk), .resetN(resetN), .triggerIn(trig0), .addrIn(addr0),
        .dataOut(data0), .readyOut(ready0), .errOut(err0), .busy(busy0),
        .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData)
    );

    imem_responder #(.LATENCY(0)) u1 (
        .clk(clk), .resetN(resetN), .triggerIn(trig1), .addrIn(addr1),
        .dataOut(data1), .readyOut(ready1), .errOut(err1), .busy(busy1),
        .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; sample 1 time unit after the last one
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        loadEn   = 1'b1;
        loadAddr = a;
        loadData = d;
        tick(1);
        loadEn   = 1'b0;
    endtask

    initial begin
        resetN   = 1'b0;
        loadEn   = 1'b0;
        loadAddr = '0;
        loadData = '0;
        trig0    = 1'b0;
        trig1    = 1'b0;
        addr0    = '0;
        addr1    = '0;
        tick(1);

        // Preload while the logic is held in reset
        preload(8'd0, 32'hE3A00001);
        preload(8'd1, 32'hE2800001);

        checkBit("rst_ready", ready0, 1'b0);
        checkBit("rst_err", err0, 1'b0);
        checkBit("rst_busy", busy0, 1'b0);
        check("rst_data", data0, 32'h0);

        resetN = 1'b1;
        tick(2);

        // 1: addr 0, toggle 0->1, response on the 6th edge
        addr0 = 32'h0;
        trig0 = 1'b1;
        tick(2);
        checkBit("t1_busy_e2", busy0, 1'b0);
        tick(1);
        checkBit("t1_busy_e3", busy0, 1'b1);
        tick(2);
        checkBit("t1_busy_e5", busy0, 1'b1);
        checkBit("t1_ready_e5", ready0, 1'b0);
        tick(1);
        checkBit("t1_ready_e6", ready0, 1'b1);
        check("t1_data", data0, 32'hE3A00001);
        checkBit("t1_err", err0, 1'b0);
        checkBit("t1_busy_e6", busy0, 1'b0);

        // 2: addr 4, toggle 1->0
        addr0 = 32'h4;
        trig0 = 1'b0;
        tick(5);
        checkBit("t2_ready_e5", ready0, 1'b1);
        tick(1);
        checkBit("t2_ready_e6", ready0, 1'b0);
        check("t2_data", data0, 32'hE2800001);
        checkBit("t2_err", err0, 1'b0);

        // 3: misaligned, then out of range
        addr0 = 32'h2;
        trig0 = 1'b1;
        tick(6);
        checkBit("t3a_ready", ready0, 1'b1);
        checkBit("t3a_err", err0, 1'b1);
        check("t3a_data", data0, Nop);
        addr0 = 32'h400;
        trig0 = 1'b0;
        tick(6);
        checkBit("t3b_ready", ready0, 1'b0);
        checkBit("t3b_err", err0, 1'b1);
        check("t3b_data", data0, Nop);

        // 4: reset asserted mid-access, then serviced again after release
        addr0 = 32'h4;
        trig0 = 1'b1;
        tick(4);
        checkBit("t4_busy_pre", busy0, 1'b1);
        resetN = 1'b0;
        #1;
        checkBit("t4_rst_busy", busy0, 1'b0);
        checkBit("t4_rst_err", err0, 1'b0);
        check("t4_rst_data", data0, 32'h0);
        checkBit("t4_rst_ready", ready0, 1'b0);
        tick(2);
        checkBit("t4_hold_ready", ready0, 1'b0);
        resetN = 1'b1;
        tick(5);
        checkBit("t4_ready_e5", ready0, 1'b0);
        tick(1);
        checkBit("t4_ready_e6", ready0, 1'b1);
        check("t4_data", data0, 32'hE2800001);

        // 5: preload write on the response edge returns the old word
        addr0 = 32'h0;
        trig0 = 1'b0;
        tick(5);
        loadEn   = 1'b1;
        loadAddr = 8'd0;
        loadData = 32'hDEADBEEF;
        tick(1);
        loadEn   = 1'b0;
        checkBit("t5_ready", ready0, 1'b0);
        check("t5_old", data0, 32'hE3A00001);
        trig0 = 1'b1;
        tick(6);
        checkBit("t5b_ready", ready0, 1'b1);
        check("t5_new", data0, 32'hDEADBEEF);

        // 6: LATENCY=0 instance, response on the 4th edge
        addr1 = 32'h4;
        trig1 = 1'b1;
        tick(3);
        checkBit("t6_busy_e3", busy1, 1'b1);
        checkBit("t6_ready_e3", ready1, 1'b0);
        tick(1);
        checkBit("t6_ready_e4", ready1, 1'b1);
        check("t6_data", data1, 32'hE2800001);
        tick(2);

        // Request 1->0, then two extra toggles arrive while it is in flight
        trig1 = 1'b0;
        tick(1);
        trig1 = 1'b1;
        tick(1);
        trig1 = 1'b0;
        tick(2);
        checkBit("t6b_ready_e4", ready1, 1'b0);
        checkBit("t6b_busy_e4", busy1, 1'b0);
        tick(4);
        checkBit("t6b_ready_late", ready1, 1'b0);
        checkBit("t6b_busy_late", busy1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
